// File: rtl/custom_logic_pkg.sv
// Shared types and helpers for the 1:2 packet fork.
// The tlast position is passed in because the data width is a parameter of the users.
package custom_logic_pkg;

    typedef enum logic {
        WAIT_FOR_FIRST = 1'b0,
        IN_PKT         = 1'b1
    } state_e;

    localparam int ROUTE_HDR = 0;
    localparam int ROUTE_RR  = 1;

    function automatic logic tlast_of(input logic [31:0] data, input int unsigned width);
        return |(data & (32'd1 << (width - 32'd1)));
    endfunction

endpackage

// File: rtl/custom_logic_skid.sv
// Two-entry skid buffer with registered input ready and registered output.
// The head entry drives the outputs directly, so data holds steady under backpressure.
module custom_logic_skid #(
    parameter int D_WIDTH = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [D_WIDTH-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [D_WIDTH-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [D_WIDTH-1:0] r_head;
    logic [D_WIDTH-1:0] r_tail;
    logic [1:0]         r_cnt;
    logic               r_ready;
    logic               w_push;
    logic               w_pop;
    logic [1:0]         w_cnt_nxt;

    assign w_push    = in_valid & r_ready;
    assign w_pop     = (r_cnt != 2'd0) & out_ready;
    assign in_ready  = r_ready;
    assign out_valid = (r_cnt != 2'd0);
    assign out_data  = r_head;

    always_comb begin
        w_cnt_nxt = r_cnt;
        case ({w_push, w_pop})
            2'b10:   w_cnt_nxt = r_cnt + 2'd1;
            2'b01:   w_cnt_nxt = r_cnt - 2'd1;
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= 2'd0;
            r_ready <= 1'b0;
            r_head  <= '0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_ready <= (w_cnt_nxt != 2'd2);
            if (w_push && ((r_cnt == 2'd0) || ((r_cnt == 2'd1) && w_pop)))
                r_head <= in_data;
            else if (w_pop && (r_cnt == 2'd2))
                r_head <= r_tail;
        end
    end

    // The tail is only ever read when r_cnt == 2, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_push && (r_cnt == 2'd1) && !w_pop)
            r_tail <= in_data;
    end

endmodule

// File: rtl/custom_logic_split.sv
// 1:2 packet fork: each whole packet goes to output A or B, decided on its first beat.
// Route comes from a header bit or from a per-packet round-robin pointer.
module custom_logic_split
    import custom_logic_pkg::*;
#(
    parameter int D_WIDTH    = 6,
    parameter int ROUTE_MODE = 0,
    parameter int DEST_BIT   = D_WIDTH - 2,
    parameter int CNT_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [D_WIDTH-1:0] up_data,
    input  logic               up_valid,
    output logic               up_ready,
    output logic [D_WIDTH-1:0] down_data_a,
    output logic               down_valid_a,
    input  logic               down_ready_a,
    output logic [D_WIDTH-1:0] down_data_b,
    output logic               down_valid_b,
    input  logic               down_ready_b,
    output logic               busy,
    output logic [CNT_W-1:0]   pkt_cnt_a,
    output logic [CNT_W-1:0]   pkt_cnt_b
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic             r_route;
    logic             r_rr_ptr;
    logic [CNT_W-1:0] r_cnt_a;
    logic [CNT_W-1:0] r_cnt_b;
    logic             w_dest;
    logic             w_sel;
    logic             w_acc;
    logic             w_tlast;
    logic             w_rdy_a;
    logic             w_rdy_b;

    assign w_dest   = (ROUTE_MODE == ROUTE_RR) ? r_rr_ptr : up_data[DEST_BIT];
    assign w_sel    = (r_state == IN_PKT) ? r_route : w_dest;
    assign up_ready = w_sel ? w_rdy_b : w_rdy_a;
    assign w_acc    = up_valid & up_ready;
    assign w_tlast  = tlast_of(32'(up_data), D_WIDTH);
    assign busy     = (r_state == IN_PKT);
    assign pkt_cnt_a = r_cnt_a;
    assign pkt_cnt_b = r_cnt_b;

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= WAIT_FOR_FIRST;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            WAIT_FOR_FIRST: if (w_acc && !w_tlast) w_state_nxt = IN_PKT;
            IN_PKT:         if (w_acc && w_tlast)  w_state_nxt = WAIT_FOR_FIRST;
            default:        w_state_nxt = WAIT_FOR_FIRST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_route  <= 1'b0;
            r_rr_ptr <= 1'b0;
            r_cnt_a  <= '0;
            r_cnt_b  <= '0;
        end else begin
            if ((r_state == WAIT_FOR_FIRST) && w_acc && !w_tlast)
                r_route <= w_dest;
            if ((ROUTE_MODE == ROUTE_RR) && w_acc && w_tlast)
                r_rr_ptr <= ~r_rr_ptr;
            // Packets are counted as they leave, not as they arrive.
            if (down_valid_a && down_ready_a && tlast_of(32'(down_data_a), D_WIDTH))
                r_cnt_a <= r_cnt_a + CNT_W'(1);
            if (down_valid_b && down_ready_b && tlast_of(32'(down_data_b), D_WIDTH))
                r_cnt_b <= r_cnt_b + CNT_W'(1);
        end
    end

    custom_logic_skid #(.D_WIDTH(D_WIDTH)) u_skid_a (
        .clk       (clk),
        .rst       (rst),
        .in_data   (up_data),
        .in_valid  (up_valid & ~w_sel),
        .in_ready  (w_rdy_a),
        .out_data  (down_data_a),
        .out_valid (down_valid_a),
        .out_ready (down_ready_a)
    );

    custom_logic_skid #(.D_WIDTH(D_WIDTH)) u_skid_b (
        .clk       (clk),
        .rst       (rst),
        .in_data   (up_data),
        .in_valid  (up_valid & w_sel),
        .in_ready  (w_rdy_b),
        .out_data  (down_data_b),
        .out_valid (down_valid_b),
        .out_ready (down_ready_b)
    );

endmodule

// File: tb/tb_custom_logic_split.sv
// Directed bench for the packet fork: header-routed instance plus a round-robin instance.
module tb_custom_logic_split;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] up_data;
    logic       up_valid;
    logic       up_ready;
    logic [5:0] down_data_a;
    logic       down_valid_a;
    logic       down_ready_a;
    logic [5:0] down_data_b;
    logic       down_valid_b;
    logic       down_ready_b;
    logic       busy;
    logic [7:0] pkt_cnt_a;
    logic [7:0] pkt_cnt_b;

    logic [5:0] rr_up_data;
    logic       rr_up_valid;
    logic       rr_up_ready;
    logic [5:0] rr_data_a;
    logic       rr_valid_a;
    logic [5:0] rr_data_b;
    logic       rr_valid_b;
    logic       rr_busy;
    logic [7:0] rr_cnt_a;
    logic [7:0] rr_cnt_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    custom_logic_split #(.D_WIDTH(6), .ROUTE_MODE(0), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .up_data      (up_data),
        .up_valid     (up_valid),
        .up_ready     (up_ready),
        .down_data_a  (down_data_a),
        .down_valid_a (down_valid_a),
        .down_ready_a (down_ready_a),
        .down_data_b  (down_data_b),
        .down_valid_b (down_valid_b),
        .down_ready_b (down_ready_b),
        .busy         (busy),
        .pkt_cnt_a    (pkt_cnt_a),
        .pkt_cnt_b    (pkt_cnt_b)
    );

    custom_logic_split #(.D_WIDTH(6), .ROUTE_MODE(1), .CNT_W(8)) dut_rr (
        .clk          (clk),
        .rst          (rst),
        .up_data      (rr_up_data),
        .up_valid     (rr_up_valid),
        .up_ready     (rr_up_ready),
        .down_data_a  (rr_data_a),
        .down_valid_a (rr_valid_a),
        .down_ready_a (1'b1),
        .down_data_b  (rr_data_b),
        .down_valid_b (rr_valid_b),
        .down_ready_b (1'b1),
        .busy         (rr_busy),
        .pkt_cnt_a    (rr_cnt_a),
        .pkt_cnt_b    (rr_cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] src [4];
        logic [5:0] got [4];
        int si;
        int ri;
        logic stray_b;

        src = '{6'h01, 6'h02, 6'h03, 6'h24};
        rst = 1'b1; up_valid = 1'b1; up_data = 6'h10;
        down_ready_a = 1'b1; down_ready_b = 1'b1;
        rr_up_valid = 1'b0; rr_up_data = 6'h00;

        // Reset held three cycles with upstream asserting valid
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_up_ready", 32'(up_ready), 32'd0);
            check("rst_valid_a", 32'(down_valid_a), 32'd0);
            check("rst_valid_b", 32'(down_valid_b), 32'd0);
        end
        check("rst_cnt_a", 32'(pkt_cnt_a), 32'd0);
        check("rst_cnt_b", 32'(pkt_cnt_b), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data_a", 32'(down_data_a), 32'd0);
        rst = 1'b0; up_valid = 1'b0;
        #1;
        check("rdy_at_release", 32'(up_ready), 32'd0);
        step();
        check("rdy_after_release", 32'(up_ready), 32'd1);

        // Header routing: 0x10,0x05,0x23 to B
        up_valid = 1'b1; up_data = 6'h10;
        #1;
        check("m0_up_ready", 32'(up_ready), 32'd1);
        step();
        check("m0_b0_valid", 32'(down_valid_b), 32'd1);
        check("m0_b0_data", 32'(down_data_b), 32'h10);
        check("m0_b0_a_quiet", 32'(down_valid_a), 32'd0);
        check("m0_b0_busy", 32'(busy), 32'd1);
        up_data = 6'h05;
        step();
        check("m0_b1_data", 32'(down_data_b), 32'h05);
        check("m0_b1_a_quiet", 32'(down_valid_a), 32'd0);
        check("m0_b1_busy", 32'(busy), 32'd1);
        up_data = 6'h23;
        step();
        check("m0_b2_data", 32'(down_data_b), 32'h23);
        check("m0_b2_busy", 32'(busy), 32'd0);
        up_valid = 1'b0;
        step();
        check("m0_b_drained", 32'(down_valid_b), 32'd0);
        check("m0_cnt_b", 32'(pkt_cnt_b), 32'd1);
        check("m0_cnt_a", 32'(pkt_cnt_a), 32'd0);

        // Route held after first beat: 0x00,0x15,0x20 all to A
        up_valid = 1'b1; up_data = 6'h00;
        step();
        check("hold_a0_data", 32'(down_data_a), 32'h00);
        check("hold_a0_valid", 32'(down_valid_a), 32'd1);
        up_data = 6'h15;
        step();
        check("hold_a1_data", 32'(down_data_a), 32'h15);
        check("hold_a1_valid", 32'(down_valid_a), 32'd1);
        check("hold_a1_b_quiet", 32'(down_valid_b), 32'd0);
        up_data = 6'h20;
        step();
        check("hold_a2_data", 32'(down_data_a), 32'h20);
        check("hold_a2_b_quiet", 32'(down_valid_b), 32'd0);
        up_valid = 1'b0;
        step();
        check("hold_cnt_a", 32'(pkt_cnt_a), 32'd1);

        // Backpressure on A for four cycles while B stays ready
        si = 0; ri = 0; stray_b = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            down_ready_a = (cyc >= 4);
            up_valid = (si < 4);
            up_data = (si < 4) ? src[si] : 6'h00;
            #1;
            if (cyc == 2) check("bp_ready_drop", 32'(up_ready), 32'd0);
            if (cyc == 3) check("bp_a_stable", 32'(down_data_a), 32'h01);
            if (down_valid_b) stray_b = 1'b1;
            if (up_valid && up_ready) si++;
            if (down_valid_a && down_ready_a) begin
                if (ri < 4) got[ri] = down_data_a;
                ri++;
            end
            step();
        end
        up_valid = 1'b0;
        check("bp_beats_out", 32'(ri), 32'd4);
        for (int k = 0; k < 4; k++)
            check($sformatf("bp_order_%0d", k), 32'(got[k]), 32'(src[k]));
        check("bp_b_never_valid", 32'(stray_b), 32'd0);
        check("bp_cnt_a", 32'(pkt_cnt_a), 32'd2);

        // Back-to-back single-beat packets: 0x30 to B, 0x20 to A
        up_valid = 1'b1; up_data = 6'h30;
        step();
        check("b2b_b_valid", 32'(down_valid_b), 32'd1);
        check("b2b_b_data", 32'(down_data_b), 32'h30);
        check("b2b_busy0", 32'(busy), 32'd0);
        up_data = 6'h20;
        step();
        check("b2b_a_valid", 32'(down_valid_a), 32'd1);
        check("b2b_a_data", 32'(down_data_a), 32'h20);
        check("b2b_b_done", 32'(down_valid_b), 32'd0);
        check("b2b_busy1", 32'(busy), 32'd0);
        up_valid = 1'b0;
        step();
        // Running totals: A had 2 packets before, B had 1
        check("b2b_cnt_a", 32'(pkt_cnt_a), 32'd3);
        check("b2b_cnt_b", 32'(pkt_cnt_b), 32'd2);

        // Round-robin instance: A,B,A,B regardless of bit4
        rr_up_valid = 1'b1; rr_up_data = 6'h30;
        step();
        check("rr0_a_valid", 32'(rr_valid_a), 32'd1);
        check("rr0_a_data", 32'(rr_data_a), 32'h30);
        check("rr0_b_quiet", 32'(rr_valid_b), 32'd0);
        rr_up_data = 6'h20;
        step();
        check("rr1_b_valid", 32'(rr_valid_b), 32'd1);
        check("rr1_b_data", 32'(rr_data_b), 32'h20);
        check("rr1_a_quiet", 32'(rr_valid_a), 32'd0);
        rr_up_data = 6'h30;
        step();
        check("rr2_a_valid", 32'(rr_valid_a), 32'd1);
        check("rr2_b_quiet", 32'(rr_valid_b), 32'd0);
        rr_up_data = 6'h20;
        step();
        check("rr3_b_valid", 32'(rr_valid_b), 32'd1);
        check("rr3_a_quiet", 32'(rr_valid_a), 32'd0);
        rr_up_valid = 1'b0;
        step();
        check("rr_cnt_a", 32'(rr_cnt_a), 32'd2);
        check("rr_cnt_b", 32'(rr_cnt_b), 32'd2);
        check("rr_busy", 32'(rr_busy), 32'd0);

        // Reset in the middle of a 4-beat packet to A with beats still buffered
        down_ready_a = 1'b0;
        up_valid = 1'b1; up_data = 6'h01;
        step();
        up_data = 6'h02;
        step();
        check("mid_busy_before", 32'(busy), 32'd1);
        check("mid_a_head", 32'(down_data_a), 32'h01);
        rst = 1'b1; up_valid = 1'b0;
        step();
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_valid_a", 32'(down_valid_a), 32'd0);
        check("mid_data_a", 32'(down_data_a), 32'd0);
        check("mid_valid_b", 32'(down_valid_b), 32'd0);
        check("mid_cnt_a", 32'(pkt_cnt_a), 32'd0);
        check("mid_up_ready", 32'(up_ready), 32'd0);
        rst = 1'b0; down_ready_a = 1'b1;
        step();
        up_valid = 1'b1; up_data = 6'h30;
        #1;
        check("mid_ready_back", 32'(up_ready), 32'd1);
        step();
        check("mid_b_valid", 32'(down_valid_b), 32'd1);
        check("mid_b_data", 32'(down_data_b), 32'h30);
        check("mid_a_quiet", 32'(down_valid_a), 32'd0);
        up_valid = 1'b0;
        step();
        check("mid_cnt_b", 32'(pkt_cnt_b), 32'd1);
        check("mid_cnt_a_after", 32'(pkt_cnt_a), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
